// File: rtl/partial_force_acc_ctrl.sv
// Round-robin front end for partial_force_acc: shares the single accumulate port
// among the filters, schedules per-register releases and runs the end-of-step flush.
package MD_pkg;
    localparam int NUM_FILTERS = 6;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } force_packet_t;
endpackage

module partial_force_acc_ctrl #(
    parameter int NUM_FILTERS = MD_pkg::NUM_FILTERS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FILTERS-1:0] frc_in_valid,
    input  MD_pkg::force_packet_t frc_in [NUM_FILTERS],
    input  logic [NUM_FILTERS-1:0] frc_in_last,
    output logic [NUM_FILTERS-1:0] frc_in_ready,
    input  logic                  flush,
    output logic                  flush_done,
    output logic                  nb_frc_valid,
    output MD_pkg::force_packet_t nb_frc,
    output logic [NUM_FILTERS-1:0] nb_reg_sel,
    output logic [NUM_FILTERS-1:0] nb_reg_release_sel
);
    localparam int PTR_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FILTERS - 1);

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH, DONE} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [NUM_FILTERS-1:0] dirty;
    logic [NUM_FILTERS-1:0] pending;

    logic [NUM_FILTERS-1:0] at_or_after_p0;
    logic [NUM_FILTERS-1:0] eligible_p0;
    logic [NUM_FILTERS-1:0] upper_p0;
    logic [NUM_FILTERS-1:0] grant_p0;
    logic [PTR_W-1:0]       grant_idx_p0;
    MD_pkg::force_packet_t  grant_frc_p0;
    logic [NUM_FILTERS-1:0] rel_cand_p0;
    logic [NUM_FILTERS-1:0] rel_pick_p0;

    function automatic logic [NUM_FILTERS-1:0] lowest_onehot(input logic [NUM_FILTERS-1:0] v);
        logic [NUM_FILTERS-1:0] r;
        r = '0;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (v[k]) begin
                r    = '0;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_FILTERS-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (v[k]) idx = idx | PTR_W'(k);
        end
        return idx;
    endfunction

    // Stage p0: combinational grant and release pick
    always_comb begin
        at_or_after_p0 = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            at_or_after_p0[k] = (PTR_W'(k) >= rr_ptr);
        end
    end

    // A register stays blocked through the cycle its release is on the bus.
    always_comb begin
        eligible_p0 = '0;
        if (rst && state == RUN) begin
            eligible_p0 = frc_in_valid & ~pending & ~nb_reg_release_sel;
        end
        upper_p0     = eligible_p0 & at_or_after_p0;
        grant_p0     = (|upper_p0) ? lowest_onehot(upper_p0) : lowest_onehot(eligible_p0);
        grant_idx_p0 = onehot_to_idx(grant_p0);

        grant_frc_p0 = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            if (grant_p0[k]) grant_frc_p0 = frc_in[k];
        end

        case (state)
            RUN:          rel_cand_p0 = pending & ~grant_p0;
            DRAIN, FLUSH: rel_cand_p0 = dirty;
            default:      rel_cand_p0 = '0;
        endcase
        rel_pick_p0 = lowest_onehot(rel_cand_p0);
    end

    assign frc_in_ready = grant_p0;

    // Stage p1: registered accumulator/release outputs and control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= RUN;
            rr_ptr             <= '0;
            dirty              <= '0;
            pending            <= '0;
            nb_frc_valid       <= 1'b0;
            nb_frc             <= '0;
            nb_reg_sel         <= '0;
            nb_reg_release_sel <= '0;
            flush_done         <= 1'b0;
        end else begin
            nb_frc_valid       <= |grant_p0;
            nb_frc             <= grant_frc_p0;
            nb_reg_sel         <= grant_p0;
            nb_reg_release_sel <= rel_pick_p0;
            flush_done         <= 1'b0;
            dirty              <= (dirty | grant_p0) & ~rel_pick_p0;
            pending            <= (pending | (grant_p0 & frc_in_last)) & ~rel_pick_p0;

            if (|grant_p0) begin
                rr_ptr <= (grant_idx_p0 == LAST_IDX) ? '0 : grant_idx_p0 + PTR_W'(1);
            end

            // FLUSH waits until the last release has actually been presented.
            case (state)
                RUN:   if (flush) state <= DRAIN;
                DRAIN: state <= FLUSH;
                FLUSH: begin
                    if (dirty == '0 && nb_reg_release_sel == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_partial_force_acc_ctrl.sv
// Scoreboard bench for partial_force_acc_ctrl: stimulus queues expected beats,
// releases, flush completions and grants; a negedge monitor pops and compares.
module tb_partial_force_acc_ctrl;
    localparam int NF = 6;

    logic                  clk;
    logic                  rst;
    logic [NF-1:0]         frc_in_valid;
    MD_pkg::force_packet_t frc_in [NF];
    logic [NF-1:0]         frc_in_last;
    logic [NF-1:0]         frc_in_ready;
    logic                  flush;
    logic                  flush_done;
    logic                  nb_frc_valid;
    MD_pkg::force_packet_t nb_frc;
    logic [NF-1:0]         nb_reg_sel;
    logic [NF-1:0]         nb_reg_release_sel;

    partial_force_acc_ctrl #(.NUM_FILTERS(NF)) dut (
        .clk                (clk),
        .rst                (rst),
        .frc_in_valid       (frc_in_valid),
        .frc_in             (frc_in),
        .frc_in_last        (frc_in_last),
        .frc_in_ready       (frc_in_ready),
        .flush              (flush),
        .flush_done         (flush_done),
        .nb_frc_valid       (nb_frc_valid),
        .nb_frc             (nb_frc),
        .nb_reg_sel         (nb_reg_sel),
        .nb_reg_release_sel (nb_reg_release_sel)
    );

    typedef struct {
        int                    cyc;
        logic [NF-1:0]         sel;
        MD_pkg::force_packet_t frc;
    } acc_t;

    typedef struct {
        int            cyc;
        logic [NF-1:0] sel;
    } sel_t;

    acc_t acc_q [$];
    sel_t rel_q [$];
    sel_t rdy_q [$];
    int   done_q [$];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic end_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic MD_pkg::force_packet_t mkf(input int k);
        MD_pkg::force_packet_t f;
        f.x = 32'h3f80_0000 | 32'(k);
        f.y = 32'h4000_0000 | (32'(k) << 8);
        f.z = 32'h4040_0000 | (32'(k) << 16);
        return f;
    endfunction

    function automatic MD_pkg::force_packet_t one_f();
        MD_pkg::force_packet_t f;
        f.x = 32'h3f80_0000;
        f.y = 32'h3f80_0000;
        f.z = 32'h3f80_0000;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [NF-1:0] v, input logic [NF-1:0] l, input logic fl);
        frc_in_valid = v;
        frc_in_last  = l;
        flush        = fl;
    endtask

    task automatic push_acc(input int c, input logic [NF-1:0] s, input MD_pkg::force_packet_t f);
        acc_t e;
        e.cyc = c; e.sel = s; e.frc = f;
        acc_q.push_back(e);
    endtask

    task automatic push_rel(input int c, input logic [NF-1:0] s);
        sel_t e;
        e.cyc = c; e.sel = s;
        rel_q.push_back(e);
    endtask

    task automatic push_rdy(input int c, input logic [NF-1:0] s);
        sel_t e;
        e.cyc = c; e.sel = s;
        rdy_q.push_back(e);
    endtask

    // Monitor: every DUT presentation is matched against the scoreboard.
    always @(negedge clk) begin
        acc_t ea;
        sel_t es;
        int   ed;
        if (!rst) begin
            total++;
            if (nb_frc_valid !== 1'b0 || nb_frc !== '0 || nb_reg_sel !== '0 ||
                nb_reg_release_sel !== '0 || flush_done !== 1'b0 || frc_in_ready !== '0) begin
                bad++;
                $display("FAIL reset_zero cyc=%0d got valid=%b sel=%b rel=%b done=%b ready=%b frc=%h, want all zero",
                         cyc, nb_frc_valid, nb_reg_sel, nb_reg_release_sel, flush_done, frc_in_ready, nb_frc);
            end
        end else begin
            if (nb_frc_valid) begin
                total++;
                if (acc_q.size() == 0) begin
                    bad++;
                    $display("FAIL acc_unexpected cyc=%0d got sel=%b, want no beat", cyc, nb_reg_sel);
                end else begin
                    ea = acc_q.pop_front();
                    if (cyc != ea.cyc || nb_reg_sel !== ea.sel || nb_frc !== ea.frc) begin
                        bad++;
                        $display("FAIL acc_beat got cyc=%0d sel=%b frc=%h, want cyc=%0d sel=%b frc=%h",
                                 cyc, nb_reg_sel, nb_frc, ea.cyc, ea.sel, ea.frc);
                    end
                end
            end else begin
                total++;
                if (nb_reg_sel !== '0 || nb_frc !== '0) begin
                    bad++;
                    $display("FAIL idle_zero cyc=%0d got sel=%b frc=%h, want zero", cyc, nb_reg_sel, nb_frc);
                end
            end

            if (nb_reg_release_sel !== '0) begin
                total++;
                if (rel_q.size() == 0) begin
                    bad++;
                    $display("FAIL rel_unexpected cyc=%0d got rel=%b, want none", cyc, nb_reg_release_sel);
                end else begin
                    es = rel_q.pop_front();
                    if (cyc != es.cyc || nb_reg_release_sel !== es.sel) begin
                        bad++;
                        $display("FAIL release got cyc=%0d rel=%b, want cyc=%0d rel=%b",
                                 cyc, nb_reg_release_sel, es.cyc, es.sel);
                    end
                end
            end

            if (flush_done === 1'b1) begin
                total++;
                if (done_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cyc=%0d", cyc);
                end else begin
                    ed = done_q.pop_front();
                    if (cyc != ed) begin
                        bad++;
                        $display("FAIL flush_done got cyc=%0d, want cyc=%0d", cyc, ed);
                    end
                end
            end

            if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
                es = rdy_q.pop_front();
                total++;
                if (frc_in_ready !== es.sel) begin
                    bad++;
                    $display("FAIL ready cyc=%0d got=%b want=%b", cyc, frc_in_ready, es.sel);
                end
            end

            total++;
            if ((nb_reg_sel & nb_reg_release_sel) != '0 || !$onehot0(nb_reg_sel) ||
                !$onehot0(nb_reg_release_sel)) begin
                bad++;
                $display("FAIL select_rules cyc=%0d got sel=%b rel=%b, want disjoint one-hot",
                         cyc, nb_reg_sel, nb_reg_release_sel);
            end
        end

        if (end_req) begin
            total++;
            if (acc_q.size() != 0) begin bad++; $display("FAIL acc_left got=%0d want=0", acc_q.size()); end
            total++;
            if (rel_q.size() != 0) begin bad++; $display("FAIL rel_left got=%0d want=0", rel_q.size()); end
            total++;
            if (done_q.size() != 0) begin bad++; $display("FAIL done_left got=%0d want=0", done_q.size()); end
            total++;
            if (rdy_q.size() != 0) begin bad++; $display("FAIL ready_left got=%0d want=0", rdy_q.size()); end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d, want completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int g;
        int n;
        for (int k = 0; k < NF; k++) frc_in[k] = mkf(k);
        rst = 1'b0;
        set_in('1, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        set_in('0, '0, 1'b0);
        rst = 1'b1;

        // All six filters: strict rotation 0..5 twice.
        for (int i = 0; i < 12; i++) begin
            tick();
            set_in('1, '0, 1'b0);
            push_rdy(cyc, NF'(1 << (i % 6)));
            push_acc(cyc + 1, NF'(1 << (i % 6)), mkf(i % 6));
        end

        // Flush with all six dirty.
        tick();
        set_in('0, '0, 1'b1);
        n = cyc;
        for (int k = 0; k < NF; k++) push_rel(n + 2 + k, NF'(1 << k));
        done_q.push_back(n + 9);
        tick();
        set_in('0, '0, 1'b0);
        repeat (9) tick();

        // Filters 0 and 2 alternate with non-last 1.0 beats.
        frc_in[0] = one_f();
        frc_in[2] = one_f();
        for (int i = 0; i < 6; i++) begin
            tick();
            set_in(6'b000101, '0, 1'b0);
            push_rdy(cyc, (i % 2 == 0) ? 6'b000001 : 6'b000100);
            push_acc(cyc + 1, (i % 2 == 0) ? 6'b000001 : 6'b000100, one_f());
        end
        tick();
        set_in('0, '0, 1'b0);
        frc_in[0] = mkf(0);
        frc_in[2] = mkf(2);

        // Filter 3 last beats: blocked until the cycle after its release.
        tick();
        set_in(6'b001000, 6'b001000, 1'b0);
        g = cyc;
        push_rdy(g, 6'b001000);
        push_acc(g + 1, 6'b001000, mkf(3));
        push_rel(g + 2, 6'b001000);
        push_rdy(g + 1, 6'b000000);
        push_rdy(g + 2, 6'b000000);
        push_rdy(g + 3, 6'b001000);
        push_acc(g + 4, 6'b001000, mkf(3));
        push_rel(g + 5, 6'b001000);
        repeat (3) tick();
        tick();
        set_in('0, '0, 1'b0);
        repeat (2) tick();

        // Filters 0 and 1 last beats on consecutive grants.
        tick();
        set_in(6'b000011, 6'b000011, 1'b0);
        g = cyc;
        push_rdy(g, 6'b000001);
        push_acc(g + 1, 6'b000001, mkf(0));
        push_rel(g + 2, 6'b000001);
        push_rel(g + 3, 6'b000010);
        tick();
        set_in(6'b000010, 6'b000010, 1'b0);
        push_rdy(g + 1, 6'b000010);
        push_acc(g + 2, 6'b000010, mkf(1));
        tick();
        set_in('0, '0, 1'b0);
        repeat (2) tick();

        // Retire filter 2, leave {1,4} dirty.
        tick();
        set_in(6'b000100, 6'b000100, 1'b0);
        g = cyc;
        push_rdy(g, 6'b000100);
        push_acc(g + 1, 6'b000100, mkf(2));
        push_rel(g + 2, 6'b000100);
        tick();
        set_in(6'b010010, '0, 1'b0);
        push_rdy(g + 1, 6'b010000);
        push_acc(g + 2, 6'b010000, mkf(4));
        tick();
        set_in(6'b000010, '0, 1'b0);
        push_rdy(g + 2, 6'b000010);
        push_acc(g + 3, 6'b000010, mkf(1));
        tick();
        set_in('0, '0, 1'b0);
        repeat (2) tick();

        // Flush {1,4} with every filter requesting throughout.
        tick();
        set_in('0, '0, 1'b1);
        n = cyc;
        push_rel(n + 2, 6'b000010);
        push_rel(n + 3, 6'b010000);
        done_q.push_back(n + 5);
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_in('1, '0, 1'b0);
            push_rdy(cyc, 6'b000000);
        end
        tick();
        set_in('0, '0, 1'b0);
        tick();

        // Flush with nothing dirty.
        tick();
        set_in('0, '0, 1'b1);
        n = cyc;
        done_q.push_back(n + 3);
        tick();
        set_in('0, '0, 1'b0);
        repeat (3) tick();

        // Reset while filter 5's last beat is pending.
        tick();
        set_in(6'b100000, 6'b100000, 1'b0);
        push_rdy(cyc, 6'b100000);
        tick();
        set_in('0, '0, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) tick();
        tick();
        set_in(6'b100000, '0, 1'b0);
        push_rdy(cyc, 6'b100000);
        push_acc(cyc + 1, 6'b100000, mkf(5));
        tick();
        set_in('0, '0, 1'b0);
        repeat (3) tick();

        end_req = 1'b1;
        repeat (5) @(posedge clk);
    end
endmodule

// File: doc/partial_force_acc_ctrl.md
# partial_force_acc_ctrl

Controller in front of `partial_force_acc` that shares the single accumulate port among `NUM_FILTERS` filter outputs and schedules register releases. Each filter streams partial forces for its current neighbour particle, flagging the final beat. The controller grants one filter per cycle with round-robin priority and drives the accumulator's valid, data and one-hot register select. It issues each register's release once that register's last beat has been accumulated, and runs an end-of-step flush that releases every dirty register.

## Interface
- `NUM_FILTERS`, default `MD_pkg::NUM_FILTERS` (benches use 6): number of filters and accumulator registers.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `frc_in_valid`  in  NUM_FILTERS  per-filter partial force present.
- `frc_in`  in  NUM_FILTERS x force_packet_t  per-filter partial force.
- `frc_in_last`  in  NUM_FILTERS  beat is the final partial force for the filter's current particle.
- `frc_in_ready`  out  NUM_FILTERS  beat accepted this cycle when valid & ready (combinational grant).
- `flush`  in  1  single-cycle request: release all dirty registers.
- `flush_done`  out  1  one-cycle pulse when the flush is complete.
- `nb_frc_valid`  out  1  to accumulator.
- `nb_frc`  out  force_packet_t  to accumulator.
- `nb_reg_sel`  out  NUM_FILTERS  one-hot accumulate select.
- `nb_reg_release_sel`  out  NUM_FILTERS  one-hot release select.

## Operation
- State machine: RUN, DRAIN, FLUSH, DONE. Reset enters RUN.
- Eligibility in RUN: filter i is eligible when `frc_in_valid[i]` and not `pending[i]`. No filter is eligible in DRAIN, FLUSH or DONE.
- Arbitration: pick the first eligible filter at or after `rr_ptr`, wrapping modulo `NUM_FILTERS`. Assert `frc_in_ready` only for the winner. On a grant, `rr_ptr` becomes winner+1, wrapping to 0. With no grant, `rr_ptr` holds.
- Grant effects: set `dirty[i]`. If `frc_in_last[i]` is set, also set `pending[i]`.
- Release, RUN only:
  - Candidates are `pending` bits whose register is not on the current `nb_reg_sel`.
  - Take the lowest-index candidate, one per cycle.
  - Drive `nb_reg_release_sel` registered from it.
  - Clear `pending` and `dirty` for that bit.
- Flush:
  - `flush` sampled in RUN during cycle N. A grant in cycle N is still allowed.
  - N+1 is DRAIN. N+2 enters FLUSH.
  - FLUSH releases the lowest-index dirty register each cycle and clears its `dirty` and `pending` bits.
  - When `dirty==0` in a FLUSH cycle, go to DONE.
  - DONE asserts `flush_done` for one cycle, then returns to RUN.
  - `flush` is ignored outside RUN.
- Accumulate and release never target the same register in one cycle.
- At most one bit is set in each select output.
- When `nb_frc_valid=0`: `nb_frc=0` and `nb_reg_sel=0`.
- Reset mid-operation: asynchronously clear all state. In-flight pending releases are dropped and no release is emitted.

## Timing
- Reset values:
  - Outputs: `nb_frc_valid=0`, `nb_frc=0`, `nb_reg_sel=0`, `nb_reg_release_sel=0`, `flush_done=0`, `frc_in_ready=0`.
  - Internal: `rr_ptr=0`, `dirty=0`, `pending=0`.
- Accumulate latency: a grant in cycle G drives the accumulator outputs in G+1.
- Release latency: a last beat granted in G produces its earliest release in G+2. If lower-index releases are queued, the release comes later, one per cycle.
- `frc_in_ready[i]` stays low from G+1 until the cycle after the release of i.
- Flush with no dirty registers: DRAIN N+1, FLUSH N+2, `flush_done` at N+3, RUN at N+4.
- Flush with k dirty registers: releases in N+2 … N+k+1, `flush_done` at N+k+3.
- Throughput: one accumulate beat per cycle while any filter is eligible.

## Test plan
- Reset, then filters 0 and 2 valid every cycle with non-last beats of 1.0 (32'h3f800000) in x/y/z:
  - `nb_reg_sel` alternates 000001 / 000100, starting one cycle after the first grant.
  - `nb_frc_valid` stays 1 and `nb_reg_release_sel` stays 0.
- Filter 3 single beat with last=1, granted in cycle G:
  - `nb_reg_sel=001000` at G+1; `nb_reg_release_sel=001000` at G+2.
  - `frc_in_ready[3]` is low from G+1 through G+2.
- Filters 0 and 1 both send last beats in consecutive grants:
  - releases 000001 then 000010 on consecutive cycles.
  - never the same bit on `nb_reg_sel` and `nb_reg_release_sel` in one cycle.
- All six filters valid every cycle for 12 cycles: the grant order is 0,1,2,3,4,5,0,… with no filter starved.
- Dirty registers {1,4}, flush pulse at cycle N:
  - no grants in N+1..N+4.
  - releases 000010 at N+2 and 010000 at N+3.
  - `flush_done` high only at N+5.
- Assert `rst` low while a last beat is pending: all outputs go 0 immediately; after reset deasserts, no release is issued for the dropped pending bit.
